apb_master_bridge: RTL

- Single-outstanding APB master that sits directly upstream of the GPIO APB slave.
- Converts a simple valid/ready request channel from the core into APB SETUP/ACCESS phases on PSEL/PENABLE/PWRITE/PADDR/PWDATA.
- Returns PRDATA through a valid/ready response channel.
- Drives exactly one APB transfer at a time.

---
 rtl/apb_master_pkg.sv | 16 +
 rtl/apb_wait_timer.sv | 32 +++
 rtl/apb_master_bridge.sv | 106 ++++++++++
 3 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB master bridge.
// Provides the FSM state type, default bus widths and the wait-counter width.
package apb_master_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned TO_W       = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter with expiry compare against a fixed limit.
// Ports: clk, rst (async high), clr (entering ACCESS), inc (wait cycle),
//        expired (limit reached on a wait cycle).
module apb_wait_timer
  import apb_master_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [TO_W-1:0] LIM = TO_W'(LIMIT);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = inc && (cnt == LIM);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: valid/ready request in, APB out, response back.
// Ports: PCLK, PRESET (async high); req_* request channel; resp_* response
//        channel; PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY APB bus.
// Build option: APB_TIMEOUT_EN adds an ACCESS wait-state limit (resp_err=1).
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  apb_state_e state;
  logic       timeout_hit;

  assign req_ready = (state == IDLE) && !PRESET;

`ifdef APB_TIMEOUT_EN
  apb_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (PCLK),
    .rst    (PRESET),
    .clr    (state == SETUP),
    .inc    ((state == ACCESS) && !PREADY),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            PWRITE  <= req_write;
            PADDR   <= req_addr;
            PWDATA  <= req_wdata;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            resp_rdata <= PWRITE ? '0 : PRDATA;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (timeout_hit) begin
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
